mp_seq_adder: RTL and testbench
===============================

MP_SEQ_ADDER -- requirements
Module: mp_seq_adder

Interface
REQ-001 Parameter WIDTH, default 256: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 32: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK >= 1.
REQ-003 iClk  input  1  sole clock, all state updates on rising edge.
REQ-004 iRstn  input  1  reset, asynchronous, active-low.
REQ-005 iValid  input  1  operand request.
REQ-006 oReady  output  1  block can accept operands.
REQ-007 iA  input  WIDTH  operand A.
REQ-008 iB  input  WIDTH  operand B.
REQ-009 iC  input  1  carry-in.
REQ-010 oValid  output  1  result available.
REQ-011 iReady  input  1  consumer takes result.
REQ-012 oSum  output  WIDTH  sum.
REQ-013 oC  output  1  carry-out of bit WIDTH-1.
REQ-014 oG  output  1  whole-word generate: carry-out that would result with carry-in 0.
REQ-015 oP  output  1  whole-word propagate: 1 when every bit of A XOR B is 1.

Function
REQ-016 FSM states IDLE, RUN, DONE; oReady SHALL be 1 only in IDLE.
REQ-017 IDLE: iValid=1 SHALL capture iA, iB, iC, clear chunk counter, go to RUN; iValid=0 stays IDLE.
REQ-018 RUN: each cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of captured A, B plus the registered carry, write that chunk of the sum register, register the chunk carry-out, increment k.
REQ-019 Chunk 0 SHALL use the captured iC as carry-in; chunk k>0 uses carry-out of chunk k-1.
REQ-020 G/P SHALL accumulate per chunk: G_acc = g_k | (p_k & G_acc), P_acc = p_k & P_acc, with G_acc=0, P_acc=1 before chunk 0.
REQ-021 After chunk NCHUNK-1 the FSM SHALL go to DONE; oValid SHALL first be 1 exactly NCHUNK cycles after the accepting edge.
REQ-022 DONE: oValid=1, oSum/oC/oG/oP stable; iReady=1 SHALL return to IDLE on that edge; iReady=0 holds DONE indefinitely.
REQ-023 No new operand SHALL be accepted in the cycle a result is taken (oReady=0 in DONE); throughput is one operation per NCHUNK+2 cycles minimum.
REQ-024 Changes on iA/iB/iC after acceptance SHALL NOT affect the result.
REQ-025 oSum, oC, oG, oP SHALL hold their last values in IDLE and during RUN, updating only at RUN->DONE.
REQ-026 iValid/iReady outside IDLE/DONE respectively SHALL be ignored.
REQ-027 NCHUNK=1: RUN lasts one cycle; oValid 1 cycle after accept.
REQ-028 Result SHALL equal (A + B + C) mod 2^WIDTH with oC the 2^WIDTH bit, for all operands including all-ones wrap.

Reset
REQ-029 iRstn=0 SHALL immediately force IDLE, oReady=1 (once released), oValid=0, oSum=0, oC=0, oG=0, oP=0, counter and carry register 0.
REQ-030 Reset during RUN or DONE SHALL abandon the operation with no result produced.
REQ-031 First accept SHALL be possible on the first rising edge after iRstn deasserts.

Configuration
REQ-032 Macro MP_ADDER_SUB_EN: when defined, SHALL add port iSub input 1, captured at accept; iSub=1 computes A + ~B + 1 (iC ignored), oC=1 meaning no borrow; oG/oP computed on A and ~B.
REQ-033 Without MP_ADDER_SUB_EN, iSub port SHALL NOT exist and behaviour is add-only per REQ-028.

Verification (WIDTH=64, CHUNK=16)
REQ-034 Accept A=0x0000_0000_0000_0001, B=0xFFFF_FFFF_FFFF_FFFF, C=0 -> oValid 4 cycles after accept, oSum=0, oC=1, oG=1, oP=0.
REQ-035 A=0x5555_5555_5555_5555, B=0xAAAA_AAAA_AAAA_AAAA, C=1 -> oSum=0, oC=1, oG=0, oP=1; same with C=0 -> oSum=0xFFFF_FFFF_FFFF_FFFF, oC=0.
REQ-036 Hold iReady=0 for 10 cycles in DONE -> oValid and oSum stable, oReady=0; then iReady=1 -> IDLE next cycle, oReady=1.
REQ-037 Drive iRstn=0 during RUN chunk 2 -> oValid=0 and all outputs 0 immediately; after release a new add A=3, B=4 -> oSum=7.
REQ-038 With MP_ADDER_SUB_EN, iSub=1, A=5, B=7 -> oSum=0xFFFF_FFFF_FFFF_FFFE, oC=0; A=7, B=5 -> oSum=2, oC=1.
REQ-039 Randomised back-to-back traffic with changing iA/iB after accept -> every result matches REQ-028 reference model.

Source files
------------

// File: rtl/mp_seq_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mp_seq_adder : multi-precision adder, CHUNK bits per cycle, with          |
// |                whole-word generate/propagate. Optional MP_ADDER_SUB_EN    |
// |                adds an iSub port for A - B (A + ~B + 1).                  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mp_seq_adder #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
`ifdef MP_ADDER_SUB_EN
  input  logic             iSub,
`endif
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oC,
  output logic             oG,
  output logic             oP
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_valid;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic [c_CW-1:0]   r_k;
  logic              r_cy;
  logic              r_gacc;
  logic              r_pacc;
  logic              r_c;
  logic              r_g;
  logic              r_p;

  logic [WIDTH-1:0]  w_b_in;
  logic              w_c_in;
  logic [CHUNK-1:0]  w_a_k;
  logic [CHUNK-1:0]  w_b_k;
  logic [CHUNK:0]    w_gs;
  logic [CHUNK:0]    w_cs;
  logic [CHUNK-1:0]  w_s;
  logic              w_g;
  logic              w_p;
  logic              w_co;
  logic              w_gacc_next;
  logic              w_pacc_next;
  logic [WIDTH-1:0]  w_acc_next;

`ifdef MP_ADDER_SUB_EN
  assign w_b_in = iSub ? ~iB : iB;
  assign w_c_in = iSub ? 1'b1 : iC;
`else
  assign w_b_in = iB;
  assign w_c_in = iC;
`endif

  // Operands shift right each RUN cycle, so the active chunk is always the low one.
  assign w_a_k = r_a[CHUNK-1:0];
  assign w_b_k = r_b[CHUNK-1:0];
  assign w_gs  = {1'b0, w_a_k} + {1'b0, w_b_k};
  assign w_cs  = {1'b0, w_gs[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_cy};
  assign w_s   = w_cs[CHUNK-1:0];
  assign w_g   = w_gs[CHUNK];
  assign w_p   = &(w_a_k ^ w_b_k);
  // w_gs[CHUNK] and w_cs[CHUNK] are never both set, so OR forms the chunk carry.
  assign w_co  = w_g | w_cs[CHUNK];

  assign w_gacc_next = w_g | (w_p & r_gacc);
  assign w_pacc_next = w_p & r_pacc;

  generate
    if (c_NCHUNK == 1) begin : g_single
      assign w_acc_next = w_s;
    end else begin : g_multi
      // Partial sum enters from the top; after NCHUNK steps chunk 0 sits at the bottom.
      logic [WIDTH-CHUNK-1:0] r_acc;

      always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
          r_acc <= '0;
        end else if (r_state == S_RUN) begin
          r_acc <= w_acc_next[WIDTH-1:CHUNK];
        end
      end

      assign w_acc_next = {w_s, r_acc};
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_cy    <= 1'b0;
      r_gacc  <= 1'b0;
      r_pacc  <= 1'b1;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_g     <= 1'b0;
      r_p     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iValid) begin
            r_a     <= iA;
            r_b     <= w_b_in;
            r_cy    <= w_c_in;
            r_k     <= '0;
            r_gacc  <= 1'b0;
            r_pacc  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> CHUNK;
          r_b    <= r_b >> CHUNK;
          r_cy   <= w_co;
          r_gacc <= w_gacc_next;
          r_pacc <= w_pacc_next;
          r_k    <= r_k + c_CW'(1);
          if (r_k == c_LAST) begin
            r_sum   <= w_acc_next;
            r_c     <= w_co;
            r_g     <= w_gacc_next;
            r_p     <= w_pacc_next;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (iReady) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oReady = r_ready;
  assign oValid = r_valid;
  assign oSum   = r_sum;
  assign oC     = r_c;
  assign oG     = r_g;
  assign oP     = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mp_seq_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mp_seq_adder : self-checking bench, WIDTH=64, CHUNK=16, random traffic |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_mp_seq_adder;

  localparam int W  = 64;
  localparam int CH = 16;
  localparam int NC = W / CH;
`ifdef MP_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         iClk   = 1'b0;
  logic         iRstn  = 1'b0;
  logic         iValid = 1'b0;
  logic         iReady = 1'b0;
  logic         iC     = 1'b0;
  logic         iSub   = 1'b0;
  logic [W-1:0] iA     = '0;
  logic [W-1:0] iB     = '0;
  logic         oReady;
  logic         oValid;
  logic [W-1:0] oSum;
  logic         oC;
  logic         oG;
  logic         oP;

  int n_chk = 0;
  int n_err = 0;

  mp_seq_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iC     (iC),
`ifdef MP_ADDER_SUB_EN
    .iSub   (iSub),
`endif
    .oValid (oValid),
    .iReady (iReady),
    .oSum   (oSum),
    .oC     (oC),
    .oG     (oG),
    .oP     (oP)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {P, G, carry, sum} straight from wide arithmetic.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic sub);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic [W:0]   gen;
    bb   = sub ? ~b : b;
    cc   = sub ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    gen  = {1'b0, a} + {1'b0, bb};
    return {&(a ^ bb), gen[W], full[W], full[W-1:0]};
  endfunction

  // Transaction-level model: busy for NC edges after accept, then holds a result.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;
  logic [W+2:0] m_pend = '0;
  logic [W+2:0] m_out  = '0;

  always @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_out  <= '0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_pend;
      end
    end else if (m_done) begin
      if (iReady) m_done <= 1'b0;
    end else if (iValid) begin
      m_pend <= ref_op(iA, iB, iC, iSub && SUB_EN);
      m_busy <= 1'b1;
      m_cnt  <= NC;
    end
  end

  always @(negedge iClk) begin
    if (iRstn) begin
      chk("cyc_oReady", W'(oReady), W'(!m_busy && !m_done));
      chk("cyc_oValid", W'(oValid), W'(m_done));
      chk("cyc_oSum",   oSum,       m_out[W-1:0]);
      chk("cyc_oC",     W'(oC),     W'(m_out[W]));
      chk("cyc_oG",     W'(oG),     W'(m_out[W+1]));
      chk("cyc_oP",     W'(oP),     W'(m_out[W+2]));
    end
  end

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return {W{1'b1}};
      1:       return '0;
      2:       return {$urandom, $urandom} | 64'hFFFF_0000_FFFF_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, output int lat);
    int t;
    t = 0;
    while (!oReady && t < 40) begin
      @(posedge iClk); #1;
      t++;
    end
    chk("accept_ready", W'(oReady), W'(1));
    iValid = 1'b1;
    iA = a; iB = b; iC = c; iSub = sub;
    @(posedge iClk); #1;
    iValid = 1'b0;
    iA = {$urandom, $urandom};
    iB = {$urandom, $urandom};
    iC = 1'($urandom);
    iSub = 1'($urandom);
    lat = 0;
    while (!oValid && lat < 40) begin
      @(posedge iClk); #1;
      lat++;
    end
    chk("result_valid", W'(oValid), W'(1));
  endtask

  task automatic take_result();
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
  endtask

  initial begin
    logic [W+2:0] r;
    int lat;

    @(posedge iClk); #1;
    r = ref_op(64'h1, {W{1'b1}}, 1'b0, 1'b0);
    chk("model_sum", r[W-1:0], 64'h0);
    chk("model_c",   W'(r[W]),   W'(1));
    chk("model_g",   W'(r[W+1]), W'(1));
    chk("model_p",   W'(r[W+2]), W'(0));
    chk("rst_oValid", W'(oValid), W'(0));
    chk("rst_oSum",   oSum, 64'h0);
    chk("rst_oC",     W'(oC), W'(0));
    chk("rst_oG",     W'(oG), W'(0));
    chk("rst_oP",     W'(oP), W'(0));
    iRstn = 1'b1;
    chk("rst_oReady", W'(oReady), W'(1));

    run_op(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, lat);
    chk("t1_latency", W'(lat), W'(4));
    chk("t1_sum", oSum, 64'h0);
    chk("t1_c", W'(oC), W'(1));
    chk("t1_g", W'(oG), W'(1));
    chk("t1_p", W'(oP), W'(0));
    take_result();

    run_op(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, lat);
    chk("t2_sum", oSum, 64'h0);
    chk("t2_c", W'(oC), W'(1));
    chk("t2_g", W'(oG), W'(0));
    chk("t2_p", W'(oP), W'(1));
    take_result();

    run_op(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, lat);
    chk("t3_sum", oSum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_c", W'(oC), W'(0));
    for (int i = 0; i < 10; i++) begin
      @(posedge iClk); #1;
      chk("hold_oValid", W'(oValid), W'(1));
      chk("hold_oReady", W'(oReady), W'(0));
      chk("hold_oSum", oSum, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    take_result();
    chk("take_oReady", W'(oReady), W'(1));
    chk("take_oValid", W'(oValid), W'(0));

    // Reset while chunk 2 is being added.
    iValid = 1'b1; iA = 64'h1234_5678_9ABC_DEF0; iB = 64'h1111_2222_3333_4444; iC = 1'b0;
    @(posedge iClk); #1;
    iValid = 1'b0;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    #2 iRstn = 1'b0;
    #1;
    chk("rr_oValid", W'(oValid), W'(0));
    chk("rr_oSum", oSum, 64'h0);
    chk("rr_oC", W'(oC), W'(0));
    chk("rr_oG", W'(oG), W'(0));
    chk("rr_oP", W'(oP), W'(0));
    @(posedge iClk); #1;
    iRstn = 1'b1;
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    chk("rr_latency", W'(lat), W'(4));
    chk("rr_sum", oSum, 64'd7);
    chk("rr_c", W'(oC), W'(0));
    take_result();

    if (SUB_EN) begin
      run_op(64'd5, 64'd7, 1'b0, 1'b1, lat);
      chk("sub1_sum", oSum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub1_c", W'(oC), W'(0));
      take_result();
      run_op(64'd7, 64'd5, 1'b0, 1'b1, lat);
      chk("sub2_sum", oSum, 64'd2);
      chk("sub2_c", W'(oC), W'(1));
      take_result();
    end

    // Random traffic; the per-cycle compare process carries the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge iClk); #1;
      if ($urandom_range(0, 299) == 0) begin
        iRstn = 1'b0;
        #2 iRstn = 1'b1;
      end
      iValid = ($urandom_range(0, 3) != 0);
      iReady = 1'($urandom);
      iA     = rand_word();
      iB     = rand_word();
      iC     = 1'($urandom);
      iSub   = 1'($urandom);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    repeat (NC + 4) @(posedge iClk);
    #1;
    chk("end_idle", W'(oReady), W'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
